// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg -- shared FSM state and read-during-write mode constants for dp_ram_bw.
// Rev 1.0
`default_nettype none

package dp_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

`default_nettype wire

// File: rtl/dp_ram_out_stage.sv
// dp_ram_out_stage -- per-port read data/valid pipeline; dout holds while valid is low.
// Rev 1.0
`default_nettype none

module dp_ram_out_stage
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      assign out_valid = s1_valid;
      assign out_data  = s1_data;
    end else begin : g_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign out_valid = s2_valid;
      assign out_data  = s2_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dp_ram_bw.sv
// dp_ram_bw -- true dual-port RAM with byte write enables, collision flag and clear-on-reset.
// Rev 1.0
`default_nettype none

module dp_ram_bw
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_a,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             valid_a,
  output logic                             valid_b,
  output logic                             busy,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_a;
  logic                    acc_b;
  logic [NB-1:0]           wr_a;
  logic [NB-1:0]           wr_b;
  logic [DATA_WIDTH-1:0]   rdata_a;
  logic [DATA_WIDTH-1:0]   rdata_b;
  logic                    collision_q;

  assign busy  = (state == CLEAR);
  assign acc_a = en_a & ~busy & ~rst;
  assign acc_b = en_b & ~busy & ~rst;
  assign wr_a  = acc_a ? we_a : '0;
  assign wr_b  = acc_b ? we_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      if (&cnt) begin
        state <= READY;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // B is written first so A's bytes take precedence when both hit the same word.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      if (!rst) begin
        mem[cnt] <= '0;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_b[k]) begin
          mem[addr_b][k*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (wr_a[k]) begin
          mem[addr_a][k*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Write-first merges only the port's own write; the other port always sees the old word.
  always_comb begin
    rdata_a = mem[addr_a];
    rdata_b = mem[addr_b];
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_a[k]) begin
          rdata_a[k*BYTE_WIDTH +: BYTE_WIDTH] = din_a[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_b[k]) begin
          rdata_b[k*BYTE_WIDTH +: BYTE_WIDTH] = din_b[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= acc_a & acc_b & (addr_a == addr_b) & (|(we_a & we_b));
    end
  end

  assign collision = collision_q;

  dp_ram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_out_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_a),
    .in_data   (rdata_a),
    .out_valid (valid_a),
    .out_data  (dout_a)
  );

  dp_ram_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_out_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_b),
    .in_data   (rdata_b),
    .out_valid (valid_b),
    .out_data  (dout_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_bw.sv
// tb_dp_ram_bw -- directed self-checking bench; three instances share stimulus
// (defaults, write-first with no output register, no clear-on-reset).
`default_nettype none

module tb_dp_ram_bw;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a [3];
  logic [31:0] dout_b [3];
  logic        valid_a [3];
  logic        valid_b [3];
  logic        busy [3];
  logic        collision [3];

  int total = 0;
  int bad   = 0;
  int n;
  logic leak;

  always #5 clk = ~clk;

  dp_ram_bw u_dut0 (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout_a[0]), .dout_b(dout_b[0]), .valid_a(valid_a[0]), .valid_b(valid_b[0]),
    .busy(busy[0]), .collision(collision[0])
  );

  dp_ram_bw #(.RDW_MODE(1), .OUT_REG(0)) u_dut1 (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout_a[1]), .dout_b(dout_b[1]), .valid_a(valid_a[1]), .valid_b(valid_b[1]),
    .busy(busy[1]), .collision(collision[1])
  );

  dp_ram_bw #(.CLEAR_ON_RESET(0)) u_dut2 (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout_a[2]), .dout_b(dout_b[2]), .valid_a(valid_a[2]), .valid_b(valid_b[2]),
    .busy(busy[2]), .collision(collision[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
  endtask

  // Apply one access cycle on both ports, then return at the following negedge.
  task automatic acc(input logic ea, input logic [3:0] wa, input logic [5:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [5:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    @(negedge clk);
    idle();
  endtask

  // Back-to-back port A reads: dut1 has latency 1, dut0 latency 2.
  task automatic read3(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [5:0]  a [3];
    logic [31:0] e [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < 3; i++) begin
      en_a = 1'b1; we_a = 4'h0; addr_a = a[i];
      @(negedge clk);
      check("rd_l1_valid", valid_a[1], 1'b1);
      check("rd_l1_data", dout_a[1], e[i]);
      if (i > 0) begin
        check("rd_l2_valid", valid_a[0], 1'b1);
        check("rd_l2_data", dout_a[0], e[i-1]);
      end
    end
    idle();
    @(negedge clk);
    check("rd_l2_last", dout_a[0], e[2]);
    check("rd_l1_drop", valid_a[1], 1'b0);
    @(negedge clk);
    check("rd_l2_drop", valid_a[0], 1'b0);
    check("rd_hold", dout_a[0], e[2]);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    @(negedge clk);
    check("rst_busy", busy[0], 1'b1);
    check("rst_busy_noclr", busy[2], 1'b0);
    check("rst_valid", valid_a[0], 1'b0);
    check("rst_dout", dout_a[0], 32'h0);
    check("rst_coll", collision[0], 1'b0);

    // Clear runs while port A hammers writes that must be ignored.
    rst = 1'b0;
    en_a = 1'b1; we_a = 4'hF; addr_a = 6'd31; din_a = 32'hDEADBEEF;
    n = 0; leak = 1'b0;
    while (busy[0] && n < 200) begin
      @(negedge clk);
      n++;
      if (valid_a[0] || valid_a[1]) leak = 1'b1;
    end
    idle();
    check("clear_len", n, 64);
    check("clear_no_valid", leak, 1'b0);
    check("clear_done_dut1", busy[1], 1'b0);

    read3(6'd0, 6'd31, 6'd63, 32'h0, 32'h0, 32'h0);

    // Byte-enable merge on addr 5 followed by a port B read.
    acc(1'b1, 4'hF, 6'd5, 32'hAABBCCDD, 1'b0, 4'h0, 6'd0, 32'h0);
    check("wf_full", dout_a[1], 32'hAABBCCDD);
    acc(1'b1, 4'b0101, 6'd5, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
    check("wf_merge", dout_a[1], 32'hAA22CC44);
    check("rf_first", dout_a[0], 32'h0);
    acc(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd5, 32'h0);
    check("rf_second", dout_a[0], 32'hAABBCCDD);
    check("b_lat2_early", valid_b[0], 1'b0);
    check("b_lat1_valid", valid_b[1], 1'b1);
    check("b_lat1_data", dout_b[1], 32'hAA22CC44);
    @(negedge clk);
    check("b_lat2_valid", valid_b[0], 1'b1);
    check("b_lat2_data", dout_b[0], 32'hAA22CC44);

    // Write/write collision on addr 9.
    acc(1'b1, 4'b0011, 6'd9, 32'h000000FF, 1'b1, 4'b0110, 6'd9, 32'h00EE0000);
    check("coll_pulse", collision[0], 1'b1);
    check("coll_pulse1", collision[1], 1'b1);
    @(negedge clk);
    check("coll_end", collision[0], 1'b0);
    acc(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd9, 32'h0);
    check("coll_word", dout_b[1], 32'h00EE00FF);
    acc(1'b1, 4'hF, 6'd10, 32'h0, 1'b1, 4'hF, 6'd11, 32'h0);
    check("coll_diff_addr", collision[0], 1'b0);
    acc(1'b1, 4'b0011, 6'd12, 32'h0, 1'b1, 4'b1100, 6'd12, 32'h0);
    check("coll_disjoint_we", collision[0], 1'b0);

    // Read-during-write on addr 3: A writes, B reads.
    acc(1'b1, 4'hF, 6'd3, 32'h1, 1'b0, 4'h0, 6'd0, 32'h0);
    acc(1'b1, 4'hF, 6'd3, 32'h2, 1'b1, 4'h0, 6'd3, 32'h0);
    check("rdw_wf_a", dout_a[1], 32'h2);
    check("rdw_wf_b", dout_b[1], 32'h1);
    @(negedge clk);
    check("rdw_rf_a", dout_a[0], 32'h1);
    check("rdw_rf_b", dout_b[0], 32'h1);

    // Consecutive reads of distinct words.
    acc(1'b1, 4'hF, 6'd1, 32'h01010101, 1'b0, 4'h0, 6'd0, 32'h0);
    acc(1'b1, 4'hF, 6'd2, 32'h02020202, 1'b0, 4'h0, 6'd0, 32'h0);
    acc(1'b1, 4'hF, 6'd3, 32'h03030303, 1'b0, 4'h0, 6'd0, 32'h0);
    @(negedge clk);
    read3(6'd1, 6'd2, 6'd3, 32'h01010101, 32'h02020202, 32'h03030303);

    // Reset lands while a read is still in dut0's pipeline.
    en_a = 1'b1; we_a = 4'h0; addr_a = 6'd5;
    @(negedge clk);
    idle();
    check("inflight_l1", valid_a[1], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("flush_valid", valid_a[0], 1'b0);
    check("flush_dout", dout_a[0], 32'h0);
    rst = 1'b0;

    // Reset at clear count 20 restarts the clear.
    leak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en_a = i[0];
      @(negedge clk);
      if (valid_a[0] || valid_a[1]) leak = 1'b1;
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy[0] && n < 200) begin
      en_a = n[0];
      @(negedge clk);
      n++;
      if (valid_a[0] || valid_a[1]) leak = 1'b1;
    end
    idle();
    check("restart_len", n, 64);
    check("restart_no_valid", leak, 1'b0);

    read3(6'd5, 6'd9, 6'd3, 32'h0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
